// File: rtl/incr_share_arbiter.sv
// Round-robin arbiter sharing one registered +1 incrementer between N_REQ requesters.
// Each operation runs IDLE -> CALC -> RESP; only one operand is ever in flight.
module incr_share_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_carry,
    output logic                   busy
);

    localparam int unsigned IdW = $clog2(N_REQ);

    typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

    state_e           stateQ, stateD;
    logic [IdW-1:0]   rrPtrQ, idQ;
    logic [WIDTH-1:0] opQ, resQ;
    logic             resCarryQ;
    logic [IdW-1:0]   winnerId;
    logic             winnerValid;

    // Round-robin search starting at rrPtrQ; the first valid requester found wins.
    always_comb begin
        int unsigned idx;
        logic [IdW-1:0] cand;
        idx         = 0;
        cand        = '0;
        winnerValid = 1'b0;
        winnerId    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx  = (32'(rrPtrQ) + k) % N_REQ;
            cand = IdW'(idx);
            if (!winnerValid && req_valid[cand]) begin
                winnerValid = 1'b1;
                winnerId    = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle:  if (winnerValid) stateD = StCalc;
            StCalc:  stateD = StResp;
            StResp:  if (rsp_ready[idQ]) stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rrPtrQ    <= '0;
            idQ       <= '0;
            opQ       <= '0;
            resQ      <= '0;
            resCarryQ <= 1'b0;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (winnerValid) begin
                        opQ <= req_data[winnerId*WIDTH +: WIDTH];
                        idQ <= winnerId;
                    end
                end
                StCalc: begin
                    {resCarryQ, resQ} <= {1'b0, opQ} + (WIDTH + 1)'(1);
                end
                StResp: begin
                    // Pointer moves on completion only, so a grant alone never skips a turn.
                    if (rsp_ready[idQ]) begin
                        rrPtrQ <= (idQ == IdW'(N_REQ - 1)) ? '0 : idQ + IdW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_carry = 1'b0;
        busy      = (stateQ != StIdle);
        unique case (stateQ)
            StIdle: begin
                if (winnerValid) req_ready[winnerId] = 1'b1;
            end
            StResp: begin
                rsp_valid[idQ] = 1'b1;
                rsp_data       = resQ;
                rsp_carry      = resCarryQ;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_incr_share_arbiter.sv
// Randomised scoreboard bench for incr_share_arbiter against a transaction-level model.
module tb_incr_share_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_data;
    logic [W-1:0]   rsp_data;
    logic           rsp_carry, busy;

    always #5 clk = ~clk;

    incr_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .busy      (busy)
    );

    typedef struct packed {
        logic [$clog2(N)-1:0] id;
        logic [W-1:0]         data;
        logic                 carry;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    // Model: owner of the datapath (-1 when free), cycles since grant, fairness pointer.
    int mOwner = -1;
    int mAge   = 0;
    int mPtr   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pickWinner(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(mPtr + k) % N]) return (mPtr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] pack4(input logic [W-1:0] b0, input logic [W-1:0] b1,
                                             input logic [W-1:0] b2, input logic [W-1:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic [N-1:0] rr);
        int           w;
        logic [N-1:0] expReady;
        logic [N-1:0] expRsp;
        logic [W-1:0] operand;
        exp_t         e;
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        rsp_ready = rr;
        #1;
        w        = pickWinner(v);
        expReady = (mOwner < 0 && w >= 0) ? N'(1) << w : '0;
        expRsp   = (mOwner >= 0 && mAge >= 2) ? N'(1) << mOwner : '0;
        check("req_ready", 32'(req_ready), 32'(expReady));
        check("busy", 32'(busy), 32'(mOwner >= 0));
        check("rsp_valid_timing", 32'(rsp_valid), 32'(expRsp));
        if (mOwner < 0) begin
            if (w >= 0) begin
                operand = d[w*W +: W];
                e.id    = w[$clog2(N)-1:0];
                e.data  = operand + 8'd1;
                e.carry = (operand == 8'hFF);
                sbQ.push_back(e);
                mOwner = w;
                mAge   = 1;
            end
        end else if (mAge >= 2 && rr[mOwner]) begin
            mPtr   = (mOwner + 1) % N;
            mOwner = -1;
        end else begin
            mAge++;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = N'($urandom);
        req_data  = ($urandom);
        rsp_ready = N'($urandom);
        sbQ.delete();
        mOwner = -1;
        mAge   = 0;
        mPtr   = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        check("rst_rsp_carry", 32'(rsp_carry), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '1);
    endtask

    // Monitor: compares every presented response against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1) begin
                if (rsp_valid != '0) begin
                    if (sbQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got rsp_valid %0h expected none", rsp_valid);
                    end else begin
                        e = sbQ[0];
                        check("rsp_id", 32'(rsp_valid), 32'(N'(1) << e.id));
                        check("rsp_data", 32'(rsp_data), 32'(e.data));
                        check("rsp_carry", 32'(rsp_carry), 32'(e.carry));
                        if (rsp_ready[e.id]) void'(sbQ.pop_front());
                    end
                end else begin
                    check("idle_rsp_data", 32'(rsp_data), 32'h0);
                    check("idle_rsp_carry", 32'(rsp_carry), 32'h0);
                end
            end
        end
    end

    initial begin
        logic [N-1:0]   v, rr;
        logic [N*W-1:0] d;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = '0;

        // Single request, basic latency.
        doReset();
        step(4'b0001, pack4(8'h05, 8'h00, 8'h00, 8'h00), '1);
        idle(3);

        // Wrap and non-wrap carries.
        step(4'b0001, pack4(8'hFF, 8'h00, 8'h00, 8'h00), '1);
        idle(3);
        step(4'b0001, pack4(8'h7F, 8'h00, 8'h00, 8'h00), '1);
        idle(3);

        // All four contend from a fresh pointer.
        doReset();
        for (int i = 0; i < 12; i++) step(4'b1111, pack4(8'h10, 8'h20, 8'h30, 8'h40), '1);
        idle(4);

        // Serve req1, then req0 and req2 together: req2 goes first.
        doReset();
        step(4'b0010, pack4(8'h00, 8'hA1, 8'h00, 8'h00), '1);
        idle(3);
        for (int i = 0; i < 8; i++) step(4'b0101, pack4(8'hB0, 8'h00, 8'hB2, 8'h00), '1);
        idle(4);

        // Response back-pressure while other requesters keep asking.
        step(4'b0001, pack4(8'h33, 8'h00, 8'h00, 8'h00), '0);
        for (int i = 0; i < 7; i++) step(4'b1110, pack4(8'h00, 8'h44, 8'h55, 8'h66), 4'b1110);
        step('0, '0, '1);
        idle(4);

        // Reset during CALC with the pointer parked at 3: next search restarts at 0.
        doReset();
        step(4'b0100, pack4(8'h00, 8'h00, 8'hC2, 8'h00), '1);
        idle(3);
        step(4'b0001, pack4(8'hC0, 8'h00, 8'h00, 8'h00), '1);
        doReset();
        step(4'b1010, pack4(8'h00, 8'hD1, 8'h00, 8'hD3), '1);
        idle(4);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) doReset();
            v = N'($urandom);
            for (int k = 0; k < N; k++) begin
                d[k*W +: W] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
                rr[k]       = ($urandom_range(0, 9) < 7);
            end
            step(v, d, rr);
        end
        idle(8);
        check("scoreboard_drained", 32'(sbQ.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
